monster_catch_ctrl: RTL and testbench
=====================================

# monster_catch_ctrl

Per-frame catch arbiter sitting directly downstream of the monster movers. It compares each monster's `topLeftX`/`topLeftY` against pacman's location once per frame and decrements a lives counter on a catch. It then freezes play for a fixed number of frames and emits a respawn pulse that returns the monster movers to their initial position. Its `playEnable` output drives the movers' `playGame` input, and it reports game-over to the top-level game controller.

## Interface
Parameters:
- OBJECT_SIZE, 32, sprite edge length in pixels, same for monster and pacman.
- CATCH_MARGIN, 8, overlap slack in pixels; catch threshold T = OBJECT_SIZE - CATCH_MARGIN, must be ≥1.
- INITIAL_LIVES, 3, lives loaded in IDLE; range 1..7.
- FREEZE_FRAMES, 60, frames of freeze after a non-fatal catch; range 1..255.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- playGame  in  1  level; game running request from the top controller.
- monsterTopLeftX  in  11 signed  monster top-left X, may be negative.
- monsterTopLeftY  in  11 signed  monster top-left Y.
- pacmanLocationX  in  11 unsigned  pacman top-left X.
- pacmanLocationY  in  11 unsigned  pacman top-left Y.
- playEnable  out  1  to the movers' playGame input; high only in RUN.
- freeze  out  1  hold all movers and the pacman controller.
- respawn  out  1  one-cycle pulse; inverted, it drives the movers' resetN.
- caught  out  1  one-cycle pulse per catch; goes to sound and score.
- lives  out  3  remaining lives.
- gameOver  out  1  level; high in OVER.

## Operation
- Overlap arithmetic:
  - dx = sext12(monsterTopLeftX) - zext12(pacmanLocationX); dy is formed the same way.
  - overlap = (|dx| < T) && (|dy| < T), computed in 12-bit signed.
- States: IDLE, RUN, CAUGHT, FREEZE, RESPAWN, OVER. All outputs are decoded from registered state or registers (Moore).
- IDLE: lives ← INITIAL_LIVES, counter ← 0. Go to RUN when playGame=1.
- RUN: playEnable=1. On startOfFrame with overlap=1, go to CAUGHT. Overlap is ignored without startOfFrame.
- CAUGHT (exactly 1 cycle): caught=1, lives ← lives-1.
  - If lives==1 on entry, go to OVER.
  - Otherwise go to FREEZE and load counter ← FREEZE_FRAMES.
  - startOfFrame is ignored in this state.
- FREEZE: freeze=1. Each startOfFrame decrements the counter. startOfFrame while counter==1 goes to RESPAWN, so FREEZE spans exactly FREEZE_FRAMES pulses.
- RESPAWN (exactly 1 cycle): respawn=1, freeze=1. Next state is RUN.
- OVER: gameOver=1, freeze=1, lives=0. Go to IDLE when playGame=0.
- Priority: playGame=0 in any state forces IDLE on the next cycle, and lives reload there. This overrides a catch in the same cycle.
- Lives never underflow: a decrement only happens from lives≥1.

## Timing
- Reset values: state IDLE, lives=INITIAL_LIVES, counter=0; playEnable, freeze, respawn, caught and gameOver all 0.
- Catch latency, with startOfFrame plus overlap at cycle t:
  - CAUGHT at t+1: caught=1, playEnable=0.
  - New lives value and freeze=1 (or gameOver=1) at t+2.
- playEnable drops one cycle after the catch frame. The movers therefore still complete that frame's position update; this is accepted.
- Freeze to respawn: respawn goes high the cycle after the FREEZE_FRAMES-th startOfFrame in FREEZE. RUN and playEnable=1 follow one cycle later.
- The first catch check after a respawn occurs on the next startOfFrame seen in RUN.
- Inputs are sampled only on the startOfFrame cycle. Mid-frame changes have no effect.

## Test plan
- Reset then playGame=1; monster (400,300), pacman (420,300), one startOfFrame:
  - caught pulses one cycle later;
  - lives 3→2 and freeze=1 one cycle after that.
- Monster (400,300), pacman (424,300), 10 frames: no catch; lives stays 3, playEnable stays 1.
- Monster (-5,10), pacman (0,0): signed dx=-5 produces a catch. Monster (-30,10), pacman (0,0): no catch.
- FREEZE_FRAMES=3 after a catch:
  - respawn pulses one cycle after the 3rd startOfFrame;
  - freeze stays high through RESPAWN, then playEnable=1.
- Three catches with INITIAL_LIVES=3: lives 3→2→1→0, gameOver=1, no respawn after the third. Dropping playGame gives IDLE with lives=3.
- playGame dropped mid-FREEZE: next cycle is IDLE, freeze=0, lives reloaded. Asserting resetN low mid-CAUGHT sets all outputs to their reset values immediately.

Source files
------------

// File: rtl/monster_catch_ctrl.sv
// Per-frame catch arbiter: once per frame it checks whether the monster overlaps
// pacman, takes a life on a catch, freezes play for a fixed number of frames,
// then pulses respawn so the movers return to their start position.
module monster_catch_ctrl #(
  parameter int OBJECT_SIZE   = 32,
  parameter int CATCH_MARGIN  = 8,
  parameter int INITIAL_LIVES = 3,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              playGame,
  input  logic signed [10:0] monsterTopLeftX,
  input  logic signed [10:0] monsterTopLeftY,
  input  logic [10:0]       pacmanLocationX,
  input  logic [10:0]       pacmanLocationY,
  output logic              playEnable,
  output logic              freeze,
  output logic              respawn,
  output logic              caught,
  output logic [2:0]        lives,
  output logic              gameOver
);

  localparam logic [11:0] T      = 12'(OBJECT_SIZE - CATCH_MARGIN);
  localparam logic [2:0]  LIVES0 = 3'(INITIAL_LIVES);
  localparam logic [7:0]  FRZ0   = 8'(FREEZE_FRAMES);

  typedef enum logic [2:0] {
    IDLE, RUN, CAUGHT, FREEZE, RESPAWN, OVER
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        lives_q;
  logic [7:0]        cnt_q;
  logic signed [11:0] dx, dy;
  logic [11:0]       adx, ady;
  logic              overlap;

  // Overlap test in 12-bit signed: monster may sit partly off-screen (negative),
  // pacman is always on-screen (unsigned), so sign- vs zero-extend.
  always_comb begin
    dx      = {monsterTopLeftX[10], monsterTopLeftX} - $signed({1'b0, pacmanLocationX});
    dy      = {monsterTopLeftY[10], monsterTopLeftY} - $signed({1'b0, pacmanLocationY});
    adx     = dx[11] ? 12'(-dx) : 12'(dx);
    ady     = dy[11] ? 12'(-dy) : 12'(dy);
    overlap = (adx < T) && (ady < T);
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; dropping playGame wins over everything, including a catch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (playGame) state_nxt = RUN;
      RUN:     if (startOfFrame && overlap) state_nxt = CAUGHT;
      CAUGHT:  state_nxt = (lives_q <= 3'd1) ? OVER : FREEZE;
      FREEZE:  if (startOfFrame && cnt_q == 8'd1) state_nxt = RESPAWN;
      RESPAWN: state_nxt = RUN;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
    if (!playGame) state_nxt = IDLE;
  end

  // Lives and freeze-frame counter. Reload happens on the same edge that enters
  // IDLE so lives are already restored in the first IDLE cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q <= LIVES0;
      cnt_q   <= 8'd0;
    end else if (!playGame || state == IDLE) begin
      lives_q <= LIVES0;
      cnt_q   <= 8'd0;
    end else begin
      case (state)
        CAUGHT: begin
          if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          if (lives_q > 3'd1)  cnt_q   <= FRZ0;
        end
        FREEZE: if (startOfFrame && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        default: ;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    playEnable = (state == RUN);
    caught     = (state == CAUGHT);
    respawn    = (state == RESPAWN);
    gameOver   = (state == OVER);
    freeze     = (state == FREEZE) || (state == RESPAWN) || (state == OVER);
    lives      = lives_q;
  end

endmodule

// File: tb/tb_monster_catch_ctrl.sv
// Directed bench for monster_catch_ctrl with a short freeze (3 frames).
module tb_monster_catch_ctrl;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              playGame;
  logic signed [10:0] monsterTopLeftX, monsterTopLeftY;
  logic [10:0]       pacmanLocationX, pacmanLocationY;
  logic              playEnable, freeze, respawn, caught, gameOver;
  logic [2:0]        lives;

  int npass = 0;
  int ntotal = 0;

  monster_catch_ctrl #(
    .OBJECT_SIZE(32), .CATCH_MARGIN(8), .INITIAL_LIVES(3), .FREEZE_FRAMES(3)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
    .monsterTopLeftX(monsterTopLeftX), .monsterTopLeftY(monsterTopLeftY),
    .pacmanLocationX(pacmanLocationX), .pacmanLocationY(pacmanLocationY),
    .playEnable(playEnable), .freeze(freeze), .respawn(respawn),
    .caught(caught), .lives(lives), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs packed as {playEnable, freeze, respawn, caught, gameOver, lives}.
  function automatic logic [7:0] outs();
    return {playEnable, freeze, respawn, caught, gameOver, lives};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle startOfFrame pulse; on return the edge that sampled it has passed.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic place(input int mx, input int my, input int px, input int py);
    monsterTopLeftX = 11'(mx);
    monsterTopLeftY = 11'(my);
    pacmanLocationX = 11'(px);
    pacmanLocationY = 11'(py);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b0;
    place(400, 300, 424, 300);
    #12;
    // reset: everything low, lives = 3
    check("reset_outs", outs(), {5'b00000, 3'd3});
    resetN = 1'b1;
    playGame = 1'b1;
    tick();
    check("run_entry", outs(), {5'b10000, 3'd3});

    // |dx| == T exactly: never a catch across 10 frames
    for (int i = 0; i < 10; i++) begin
      frame();
      tick();
    end
    check("no_catch_10", outs(), {5'b10000, 3'd3});

    // overlap without startOfFrame is ignored
    place(400, 300, 420, 300);
    tick(); tick();
    check("midframe_ignored", outs(), {5'b10000, 3'd3});

    // catch: caught at t+1, lives/freeze at t+2
    frame();
    check("caught_pulse", outs(), {5'b00010, 3'd3});
    tick();
    check("freeze_lives2", outs(), {5'b01000, 3'd2});

    // freeze for 3 frames then respawn
    frame(); tick();
    frame(); tick();
    check("freeze_2frames", outs(), {5'b01000, 3'd2});
    frame();
    check("respawn_pulse", outs(), {5'b01100, 3'd2});
    tick();
    check("run_after_respawn", outs(), {5'b10000, 3'd2});

    // signed dx: -30 misses, -5 catches
    place(-30, 10, 0, 0);
    frame();
    check("neg_miss", outs(), {5'b10000, 3'd2});
    tick();
    place(-5, 10, 0, 0);
    frame();
    check("neg_catch", outs(), {5'b00010, 3'd2});
    tick();
    check("freeze_lives1", outs(), {5'b01000, 3'd1});
    frame(); tick(); frame(); tick(); frame();
    check("respawn2", outs(), {5'b01100, 3'd1});
    tick();
    check("run2", outs(), {5'b10000, 3'd1});

    // third catch: game over, no respawn
    frame();
    check("caught3", outs(), {5'b00010, 3'd1});
    tick();
    check("over", outs(), {5'b01001, 3'd0});
    for (int i = 0; i < 4; i++) begin
      frame(); tick();
    end
    check("over_hold", outs(), {5'b01001, 3'd0});
    playGame = 1'b0;
    tick();
    check("over_to_idle", outs(), {5'b00000, 3'd3});

    // playGame dropped mid-FREEZE
    playGame = 1'b1;
    tick();
    frame();
    tick();
    check("freeze_again", outs(), {5'b01000, 3'd2});
    frame();
    playGame = 1'b0;
    tick();
    check("drop_in_freeze", outs(), {5'b00000, 3'd3});

    // playGame=0 overrides a catch in the same cycle
    playGame = 1'b1;
    tick();
    check("run3", outs(), {5'b10000, 3'd3});
    startOfFrame = 1'b1;
    playGame = 1'b0;
    tick();
    startOfFrame = 1'b0;
    check("drop_beats_catch", outs(), {5'b00000, 3'd3});

    // async reset in CAUGHT
    playGame = 1'b1;
    tick();
    frame();
    check("caught4", outs(), {5'b00010, 3'd3});
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset", outs(), {5'b00000, 3'd3});
    tick();
    check("reset_held", outs(), {5'b00000, 3'd3});
    resetN = 1'b1;
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
